seg7_scan3: RTL and testbench

Three-digit multiplexed 7-segment display driver. Sits directly downstream of the hex-to-BCD/7-segment encoder and consumes its three segment patterns (`digi_0`, `digi_1`, `digi_2`). It time-multiplexes the patterns onto one shared segment bus with per-digit enables. A guard interval at the start of each digit slot suppresses ghosting.

---
 rtl/seg7_scan3.sv | 113 +++++++++++
 tb/tb_seg7_scan3.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan3.sv
// Three-digit multiplexed 7-segment scanner. Each digit slot starts with a dark guard, and the shadow registers refresh only at a frame boundary.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading "0" glyphs on digits 2 and 1.
module seg7_scan3 #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] digi_0,
  input  logic [6:0] digi_1,
  input  logic [6:0] digi_2,
  output logic [6:0] seg,
  output logic [2:0] dig_n,
  output logic       frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       slot_reg, slot_next;
  logic [2:0][6:0]  sh_reg, sh_next;
  logic [6:0]       seg_reg, seg_next;
  logic [2:0]       dig_n_reg, dig_n_next;
  logic             fd_reg, fd_next;

  logic             cnt_wrap;
  logic             frame_end;
  logic             lit;
  logic [2:0]       blank_mask;
  logic [2:0][6:0]  glyph;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] GLYPH_ZERO = 7'b0111111;
  // Digit 1 is only suppressed when digit 2 is also suppressed; digit 0 always shows.
  assign blank_mask = {(sh_reg[2] == GLYPH_ZERO),
                       (sh_reg[2] == GLYPH_ZERO) && (sh_reg[1] == GLYPH_ZERO),
                       1'b0};
`else
  assign blank_mask = 3'b000;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_glyph
      assign glyph[gi] = blank_mask[gi] ? 7'b0000000 : sh_reg[gi];
    end
  endgenerate

  always_comb begin
    cnt_next   = cnt_reg;
    slot_next  = slot_reg;
    sh_next    = sh_reg;
    seg_next   = 7'b0000000;
    dig_n_next = 3'b111;
    fd_next    = 1'b0;

    cnt_wrap  = (cnt_reg == CNT_MAX);
    frame_end = enable && cnt_wrap && (slot_reg == 2'd2);
    lit       = enable && (cnt_reg >= BLANK_END);

    if (!enable) begin
      cnt_next  = '0;
      slot_next = 2'd0;
    end else begin
      cnt_next = cnt_wrap ? '0 : cnt_reg + 1'b1;
      if (slot_reg == 2'd3)
        slot_next = 2'd0;
      else if (cnt_wrap)
        slot_next = (slot_reg == 2'd2) ? 2'd0 : slot_reg + 2'd1;
    end

    // While idle the shadows track the inputs so a restart shows fresh data.
    if (!enable || frame_end)
      sh_next = {digi_2, digi_1, digi_0};

    fd_next = frame_end;

    if (lit) begin
      case (slot_reg)
        2'd0: begin dig_n_next = 3'b110; seg_next = glyph[0]; end
        2'd1: begin dig_n_next = 3'b101; seg_next = glyph[1]; end
        2'd2: begin dig_n_next = 3'b011; seg_next = glyph[2]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      slot_reg  <= 2'd0;
      sh_reg    <= '0;
      seg_reg   <= 7'b0000000;
      dig_n_reg <= 3'b111;
      fd_reg    <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      slot_reg  <= slot_next;
      sh_reg    <= sh_next;
      seg_reg   <= seg_next;
      dig_n_reg <= dig_n_next;
      fd_reg    <= fd_next;
    end
  end

  assign seg        = seg_reg;
  assign dig_n      = dig_n_reg;
  assign frame_done = fd_reg;

endmodule

// File: tb/tb_seg7_scan3.sv
// Self-checking bench for seg7_scan3 at SCAN_DIV=8, BLANK_CYCLES=2: table-driven frames plus coherency, enable-drop and async-reset sequences.
module tb_seg7_scan3;

  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 3 * SCAN_DIV;
  localparam logic [6:0] Z = 7'b0111111;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] d0, d1, d2;
  logic [6:0] seg;
  logic [2:0] dig_n;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] dig_n;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [6:0] d0, d1, d2;
    logic [6:0] e0, e1, e2;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  seg7_scan3 #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable),
    .digi_0(d0), .digi_1(d1), .digi_2(d2),
    .seg(seg), .dig_n(dig_n), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  function automatic exp_t dark();
    exp_t e;
    e.seg = 7'b0000000; e.dig_n = 3'b111; e.fd = 1'b0;
    return e;
  endfunction

  // Expected pins after the j-th edge since scanning (re)started, showing frame f0..f2.
  function automatic exp_t expect_at(int j, logic [6:0] f0, logic [6:0] f1, logic [6:0] f2);
    exp_t e = dark();
    int ph = j % SCAN_DIV;
    int s  = (j / SCAN_DIV) % 3;
    e.fd = ((j % FRAME) == FRAME - 1);
    if (ph >= BLANK) begin
      case (s)
        0: begin e.dig_n = 3'b110; e.seg = f0; end
        1: begin e.dig_n = 3'b101; e.seg = f1; end
        default: begin e.dig_n = 3'b011; e.seg = f2; end
      endcase
    end
    return e;
  endfunction

  task automatic cycle(input exp_t e, input string tag);
    exp_t got, want;
    sb.push_back(e);
    @(posedge clock);
    #1;
    want = sb.pop_front();
    got.seg = seg; got.dig_n = dig_n; got.fd = frame_done;
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got seg=%b dig_n=%b frame_done=%b, expected seg=%b dig_n=%b frame_done=%b",
               tag, got.seg, got.dig_n, got.fd, want.seg, want.dig_n, want.fd);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] old_d1, new_d1;

    vecs[0] = '{7'b1011001, 7'b1110110, 7'b0011000, 7'b1011001, 7'b1110110, 7'b0011000};
    vecs[3] = '{Z, Z, 7'b1001111, Z, Z, 7'b1001111};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vecs[1] = '{7'b1011001, Z, Z, 7'b1011001, 7'b0000000, 7'b0000000};
    vecs[2] = '{Z, 7'b0000110, Z, Z, 7'b0000110, 7'b0000000};
    vecs[4] = '{Z, Z, Z, Z, 7'b0000000, 7'b0000000};
`else
    vecs[1] = '{7'b1011001, Z, Z, 7'b1011001, Z, Z};
    vecs[2] = '{Z, 7'b0000110, Z, Z, 7'b0000110, Z};
    vecs[4] = '{Z, Z, Z, Z, Z, Z};
`endif

    rst_n = 1'b0; enable = 1'b0; d0 = '0; d1 = '0; d2 = '0;
    #12;
    check_val("reset seg", int'(seg), 0);
    check_val("reset dig_n", int'(dig_n), 7);
    check_val("reset frame_done", int'(frame_done), 0);
    rst_n = 1'b1;
    cycle(dark(), "idle0");
    cycle(dark(), "idle1");
    $display("reset: outputs dark after reset and while idle");

    for (int v = 0; v < 5; v++) begin
      d0 = vecs[v].d0; d1 = vecs[v].d1; d2 = vecs[v].d2;
      enable = 1'b0;
      cycle(dark(), $sformatf("vec%0d load", v));
      enable = 1'b1;
      for (int j = 0; j < FRAME; j++)
        cycle(expect_at(j, vecs[v].e0, vecs[v].e1, vecs[v].e2), $sformatf("vec%0d j=%0d", v, j));
      enable = 1'b0;
      $display("vec %0d: digi=%b/%b/%b expect=%b/%b/%b", v, vecs[v].d0, vecs[v].d1, vecs[v].d2,
               vecs[v].e0, vecs[v].e1, vecs[v].e2);
    end

    // Frame coherency: digi_1 changes in slot 0, appears only in the following frame.
    old_d1 = 7'b1110110; new_d1 = 7'b1111101;
    d0 = 7'b1011001; d1 = old_d1; d2 = 7'b0011000;
    enable = 1'b0;
    cycle(dark(), "coh load");
    enable = 1'b1;
    for (int j = 0; j < 2 * FRAME; j++) begin
      cycle(expect_at(j, 7'b1011001, (j < FRAME) ? old_d1 : new_d1, 7'b0011000),
            $sformatf("coh j=%0d", j));
      if (j == 4) d1 = new_d1;
    end
    $display("coherency: digi_1 %b -> %b held back to next frame", old_d1, new_d1);

    // Enable drop mid-slot 1, new digit 0 loaded while idle, then resume.
    enable = 1'b0;
    cycle(dark(), "drop load");
    enable = 1'b1;
    for (int j = 0; j <= 10; j++)
      cycle(expect_at(j, 7'b1011001, new_d1, 7'b0011000), $sformatf("drop pre j=%0d", j));
    enable = 1'b0;
    d0 = 7'b0000110;
    for (int k = 0; k < 30; k++)
      cycle(dark(), $sformatf("drop low k=%0d", k));
    enable = 1'b1;
    for (int j = 0; j <= 18; j++)
      cycle(expect_at(j, 7'b0000110, new_d1, 7'b0011000), $sformatf("drop resume j=%0d", j));
    $display("enable drop: dark while low, restart at slot-0 guard");

    // Async reset pulse between edges during slot 2.
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async seg", int'(seg), 0);
    check_val("async dig_n", int'(dig_n), 7);
    check_val("async frame_done", int'(frame_done), 0);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 2 * FRAME; j++) begin
      if (j < FRAME)
        cycle(expect_at(j, 7'b0, 7'b0, 7'b0), $sformatf("post-reset j=%0d", j));
      else
        cycle(expect_at(j, 7'b0000110, new_d1, 7'b0011000), $sformatf("post-reset j=%0d", j));
    end
    $display("async reset: immediate dark, blank first frame, data after frame_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
